ibex_rf_secure_sequencer: RTL

Access sequencer that drives the secure (one-hot-enable) register file ports on behalf of the decode and writeback stages. It turns address-based read and write requests into the masked protocol the register file expects: a two-phase clear-then-write on the write port, and a precharge-then-capture on the read ports. It sits between the core's operand/writeback logic and the flip-flop register file, and it owns the sec_bwlogic first-cycle signal.

---
 rtl/ibex_rf_secure_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ibex_rf_secure_sequencer.sv
// Sequences masked register-file accesses: clear-then-write on the write port,
// precharge-then-capture on the two read ports. All RF-side outputs are flopped.
module ibex_rf_secure_sequencer #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_req_i,
    input  logic [4:0]           wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 wr_gnt_o,
    output logic                 wr_done_o,
    input  logic                 rd_req_i,
    input  logic [4:0]           rd_addr_a_i,
    input  logic [4:0]           rd_addr_b_i,
    output logic                 rd_gnt_o,
    output logic                 rd_valid_o,
    output logic [DataWidth-1:0] rd_data_a_o,
    output logic [DataWidth-1:0] rd_data_b_o,
    output logic                 sec_bwlogic_first_cycle_o,
    output logic [31:0]          read_enable_a_o,
    output logic [31:0]          read_enable_b_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [31:0]          write_enable_secure_o,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o
);
    typedef enum logic [2:0] {IDLE, WR_CLEAR, WR_DATA, RD_PRE, RD_CAP} state_e;

    state_e               state_q, state_d;
    logic [4:0]           wr_addr_q, wr_addr_d, rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;
    logic                 we_q, we_d, first_q, first_d, rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d, rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic [31:0]          wmask_q, wmask_d, ren_a_q, ren_a_d, ren_b_q, ren_b_d;
    logic                 wr_active;

    function automatic logic [31:0] onehot(input logic [4:0] a);
        onehot = 32'b1 << a;
    endfunction

    // Addresses outside RV32E space behave as unmapped: no write, no read enable.
    function automatic logic rd_legal(input logic [4:0] a);
        rd_legal = !(RV32E && a[4]);
    endfunction

    function automatic logic wr_legal(input logic [4:0] a);
        wr_legal = (a != 5'd0) && rd_legal(a);
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_gnt_o    = 1'b0;
        rd_gnt_o    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        case (state_q)
            IDLE: begin
                if (rst_ni && wr_req_i) begin
                    wr_gnt_o  = 1'b1;
                    wr_addr_d = wr_addr_i;
                    wr_data_d = wr_data_i;
                    state_d   = WR_CLEAR;
                end else if (rst_ni && rd_req_i) begin
                    rd_gnt_o    = 1'b1;
                    rd_addr_a_d = rd_addr_a_i;
                    rd_addr_b_d = rd_addr_b_i;
                    state_d     = RD_PRE;
                end
            end
            WR_CLEAR: state_d = WR_DATA;
            WR_DATA:  state_d = IDLE;
            RD_PRE:   state_d = RD_CAP;
            RD_CAP:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // RF-side outputs are derived from the next state so they leave flops cleanly.
    always_comb begin
        wr_active = (state_d == WR_CLEAR) || (state_d == WR_DATA);
        we_d      = wr_active && wr_legal(wr_addr_d);
        waddr_d   = wr_active ? wr_addr_d : 5'd0;
        wdata_d   = (state_d == WR_DATA) ? wr_data_d : '0;
        first_d   = (state_d == WR_CLEAR);
        wmask_d   = we_d ? onehot(wr_addr_d) : 32'd0;
        ren_a_d   = ((state_d == RD_CAP) && rd_legal(rd_addr_a_d)) ? onehot(rd_addr_a_d) : 32'd0;
        ren_b_d   = ((state_d == RD_CAP) && rd_legal(rd_addr_b_d)) ? onehot(rd_addr_b_d) : 32'd0;
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (state_d == RD_PRE) begin
            rd_data_a_d = '0;
            rd_data_b_d = '0;
        end else if (state_q == RD_CAP) begin
            rd_data_a_d = (wr_legal(rd_addr_a_q)) ? rf_rdata_a_i : '0;
            rd_data_b_d = (wr_legal(rd_addr_b_q)) ? rf_rdata_b_i : '0;
        end
        rd_valid_d = (state_q == RD_CAP);
        wr_done_d  = (state_q == WR_DATA);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ren_a_q     <= '0;
            ren_b_q     <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            we_q        <= we_d;
            first_q     <= first_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ren_a_q     <= ren_a_d;
            ren_b_q     <= ren_b_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_valid_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign we_a_o                    = we_q;
    assign sec_bwlogic_first_cycle_o = first_q;
    assign waddr_a_o                 = waddr_q;
    assign wdata_a_o                 = wdata_q;
    assign write_enable_secure_o     = wmask_q;
    assign read_enable_a_o           = ren_a_q;
    assign read_enable_b_o           = ren_b_q;
    assign rd_data_a_o               = rd_data_a_q;
    assign rd_data_b_o               = rd_data_b_q;
    assign rd_valid_o                = rd_valid_q;
    assign wr_done_o                 = wr_done_q;
endmodule
